demod_bit_packer: RTL and testbench
===================================

# demod_bit_packer

Downstream consumer of the ML demodulator's serial soft-output stream. Accepts one {LLR, hard bit} per handshake, packs hard bits LSB-first into WORD_W-bit words and tracks the minimum LLR magnitude (least-reliable bit) per word. Completed words are buffered in a small FIFO with a valid/ready output port, with frame-boundary marking for the downstream framer/CRC stage.

## Interface
- WORD_W, 32: hard bits per output word (power of 2, 8..64)
- FRAME_WORDS, 8: words per frame; last word of a frame is flagged
- FIFO_DEPTH, 4: output word FIFO entries (power of 2, ≥2)
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_rd_vld  in  1  demodulator output valid
- i_llr  in  8  LLR, two's complement
- i_hard_bit  in  1  hard decision bit
- o_rd_rdy  out  1  ready to accept a bit
- i_flush  in  1  single-cycle pulse: emit partial word and end frame
- o_word_vld  out  1  FIFO head valid
- o_word  out  WORD_W  packed hard bits; bit 0 = first accepted bit
- o_min_abs  out  7  min |LLR| over bits of o_word
- o_frame_last  out  1  o_word is last word of its frame
- o_nbits  out  log2(WORD_W)+1  valid bit count in o_word (WORD_W unless flushed)
- i_word_rdy  in  1  downstream ready
- o_frame_cnt  out  16  frames completed, wraps 0xFFFF→0

## Operation
- Accept: bit accepted on rising edge when i_rd_vld && o_rd_rdy.
- o_rd_rdy = (fifo_count < FIFO_DEPTH); combinational from registered count, no dependency on i_rd_vld.
- Pack register: accepted bit written at position bit_idx; bit_idx increments; positions above bit_idx are 0.
- |LLR|: llr ≥ 0 → llr[6:0]; llr < 0 → -llr; -128 saturates to 127. min_acc = min(min_acc, |LLR|); min_acc restarts at 127 for each new word (first bit's |LLR| loaded directly).
- Word complete: when accepted bit is bit WORD_W-1, push {word, min, last, nbits=WORD_W} into FIFO on the same edge; bit_idx→0, min_acc→127.
- Frame: word_idx counts pushed words 0..FRAME_WORDS-1; last = (word_idx == FRAME_WORDS-1); on last push word_idx→0, o_frame_cnt+1.
- Flush: i_flush with bit_idx>0 (counting a bit accepted that same cycle) pushes partial word zero-padded, nbits = bits held, last=1, word_idx→0, o_frame_cnt+1. Flush with bit_idx==0 and no bit accepted: if word_idx>0, previously pushed words are not modified; frame counter +1, word_idx→0, no push. If word_idx==0 too, no effect.
- Flush when FIFO is full and a partial word is held: flush is ignored (o_rd_rdy low implies full); upstream must hold i_flush until o_rd_rdy=1 — documented requirement, not checked.
- Flush coincident with a word-completing bit: single push of full word with last=1.
- Pop: on edge with o_word_vld && i_word_rdy. Push and pop same cycle: count unchanged, both occur. Pointers wrap modulo FIFO_DEPTH.
- o_word/o_min_abs/o_frame_last/o_nbits driven from FIFO head; driven 0 when o_word_vld=0.

## Timing
- Reset (async): bit_idx=0, min_acc=127, word_idx=0, FIFO empty, o_frame_cnt=0; o_word_vld=0, o_word=0, o_min_abs=0, o_frame_last=0, o_nbits=0, o_rd_rdy=1 while and after reset deasserts.
- Reset mid-word/mid-frame discards partial word and all FIFO contents immediately.
- Latency: word-completing bit accepted at edge k → o_word_vld=1 in cycle after edge k (1 cycle).
- Throughput: 1 bit/cycle sustained while i_word_rdy=1; o_rd_rdy drops the cycle after FIFO reaches FIFO_DEPTH, rises the cycle after a pop.
- Output holds stable while o_word_vld && !i_word_rdy.

## Test plan
- WORD_W=32: 32 bits alternating 1,0 with LLR=-20/+20, i_word_rdy=1 → one word 0x55555555, o_min_abs=20, o_nbits=32, valid 1 cycle after bit 31.
- LLR sequence includes -128 and 3 within one word, others ±50 → o_min_abs=3; word of all -128 → o_min_abs=127.
- FRAME_WORDS=8, 256 continuous bits → 8 words, o_frame_last only on 8th, o_frame_cnt=1.
- i_word_rdy=0, stream 4×32+5 bits → 4 words queued, o_rd_rdy=0 after 4th push, 5 extra bits stall; raise i_word_rdy → stalled bits resume, no bit lost or duplicated.
- 13 bits then i_flush → word with bits[12:0] as sent, [31:13]=0, o_nbits=13, o_frame_last=1; flush coincident with bit 32 → single full word, last=1.
- Assert i_reset after 17 bits with 2 words queued → o_word_vld=0 immediately, next 32 bits form a clean word starting at bit 0, o_frame_cnt=0.

Source files
------------

// File: rtl/demod_bit_packer_if.sv
// demod_bit_packer_if: signal bundle for the bit packer.
//   Upstream side : i_rd_vld, i_llr, i_hard_bit, i_flush -> packer; o_rd_rdy <- packer
//   Downstream    : o_word_vld, o_word, o_min_abs, o_frame_last, o_nbits, o_frame_cnt <- packer;
//                   i_word_rdy -> packer
//   slave  modport: the packer's view.
//   master modport: the environment's view (demodulator + downstream framer).
interface demod_bit_packer_if #(
  parameter int WORD_W = 32
);
  localparam int NB_W = $clog2(WORD_W) + 1;

  logic              i_rd_vld;
  logic [7:0]        i_llr;
  logic              i_hard_bit;
  logic              o_rd_rdy;
  logic              i_flush;
  logic              o_word_vld;
  logic [WORD_W-1:0] o_word;
  logic [6:0]        o_min_abs;
  logic              o_frame_last;
  logic [NB_W-1:0]   o_nbits;
  logic              i_word_rdy;
  logic [15:0]       o_frame_cnt;

  modport slave (
    input  i_rd_vld, i_llr, i_hard_bit, i_flush, i_word_rdy,
    output o_rd_rdy, o_word_vld, o_word, o_min_abs, o_frame_last, o_nbits, o_frame_cnt
  );

  modport master (
    output i_rd_vld, i_llr, i_hard_bit, i_flush, i_word_rdy,
    input  o_rd_rdy, o_word_vld, o_word, o_min_abs, o_frame_last, o_nbits, o_frame_cnt
  );
endinterface

// File: rtl/demod_bit_packer.sv
// demod_bit_packer: packs the demodulator's serial hard bits LSB-first into
// WORD_W-bit words, tracking the minimum |LLR| of each word, and queues the
// finished words in a FIFO_DEPTH-entry FIFO with frame-last marking.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   bus (slave)    : bit input handshake (i_rd_vld/o_rd_rdy, i_llr, i_hard_bit),
//                    i_flush pulse, word output handshake (o_word_vld/i_word_rdy)
//                    with o_word, o_min_abs, o_frame_last, o_nbits, and o_frame_cnt.
module demod_bit_packer #(
  parameter int WORD_W      = 32,
  parameter int FRAME_WORDS = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  demod_bit_packer_if.slave  bus
);
  localparam int IDX_W = $clog2(WORD_W);
  localparam int NB_W  = IDX_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WI_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] pack_reg;
  logic [6:0]        min_acc;
  logic [WI_W-1:0]   word_idx;
  logic [15:0]       frame_cnt;

  logic [WORD_W-1:0] mem_word [FIFO_DEPTH];
  logic [6:0]        mem_min  [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [NB_W-1:0]   mem_nb   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              rd_rdy, accept, word_done, push, pop, word_last, frame_end, word_vld;
  logic [7:0]        llr_neg;
  logic [6:0]        llr_abs, min_nxt;
  logic [WORD_W-1:0] pack_nxt;
  logic [NB_W-1:0]   bits_held;

  assign llr_neg = -bus.i_llr;

  always_comb begin
    rd_rdy   = (count < CNT_W'(FIFO_DEPTH));
    accept   = bus.i_rd_vld && rd_rdy;
    word_vld = (count != '0);
    pop      = word_vld && bus.i_word_rdy;

    // -128 has no positive counterpart in 8 bits; clamp to 127
    if (!bus.i_llr[7])          llr_abs = bus.i_llr[6:0];
    else if (bus.i_llr == 8'h80) llr_abs = 7'd127;
    else                        llr_abs = llr_neg[6:0];

    pack_nxt = pack_reg;
    min_nxt  = min_acc;
    if (accept) begin
      pack_nxt[bit_idx] = bus.i_hard_bit;
      if (bit_idx == '0 || llr_abs < min_acc) min_nxt = llr_abs;
    end

    // Bits in the word including one accepted this cycle; lets a flush on the
    // same edge as a bit still emit it, and a flush on the completing bit
    // collapse into a single full-word push.
    bits_held = {1'b0, bit_idx} + NB_W'(accept);
    word_done = accept && (bit_idx == IDX_W'(WORD_W - 1));
    // A held partial word cannot be flushed into a full FIFO; flush is dropped
    push      = rd_rdy && (word_done || (bus.i_flush && bits_held != '0));
    word_last = bus.i_flush || (word_idx == WI_W'(FRAME_WORDS - 1));
    frame_end = (push && word_last) ||
                (bus.i_flush && bits_held == '0 && word_idx != '0);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bit_idx   <= '0;
      pack_reg  <= '0;
      min_acc   <= 7'd127;
      word_idx  <= '0;
      frame_cnt <= '0;
    end else begin
      if (push) begin
        bit_idx  <= '0;
        pack_reg <= '0;
        min_acc  <= 7'd127;
      end else if (accept) begin
        bit_idx  <= bit_idx + IDX_W'(1);
        pack_reg <= pack_nxt;
        min_acc  <= min_nxt;
      end
      if (frame_end)  word_idx <= '0;
      else if (push)  word_idx <= word_idx + WI_W'(1);
      if (frame_end)  frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: outputs are gated by word_vld
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_word[wr_ptr] <= pack_nxt;
      mem_min[wr_ptr]  <= min_nxt;
      mem_last[wr_ptr] <= word_last;
      mem_nb[wr_ptr]   <= bits_held;
    end
  end

  assign bus.o_rd_rdy     = rd_rdy;
  assign bus.o_word_vld   = word_vld;
  assign bus.o_word       = word_vld ? mem_word[rd_ptr] : '0;
  assign bus.o_min_abs    = word_vld ? mem_min[rd_ptr]  : '0;
  assign bus.o_frame_last = word_vld ? mem_last[rd_ptr] : 1'b0;
  assign bus.o_nbits      = word_vld ? mem_nb[rd_ptr]   : '0;
  assign bus.o_frame_cnt  = frame_cnt;
endmodule

// File: tb/tb_demod_bit_packer.sv
module tb_demod_bit_packer;
  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  demod_bit_packer_if #(.WORD_W(32)) bus ();

  demod_bit_packer #(.WORD_W(32), .FRAME_WORDS(8), .FIFO_DEPTH(4)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] bits;
    int          nsend;
    logic [7:0]  llr_a;      // LLR on even bit positions
    logic [7:0]  llr_b;      // LLR on odd bit positions
    int          spc1_pos;   // -1 = unused
    logic [7:0]  spc1_llr;
    int          spc2_pos;
    logic [7:0]  spc2_llr;
    int          flush_mode; // 0 none, 1 with last bit, 2 separate cycle after
    logic        exp_push;
    logic [31:0] exp_word;
    logic [6:0]  exp_min;
    logic [5:0]  exp_nbits;
    logic        exp_last;
    logic [15:0] exp_fc;
  } vec_t;

  vec_t vecs[8];

  logic [31:0] got[$];
  logic        mon_en = 1'b0;

  always @(negedge i_clk)
    if (mon_en && bus.o_word_vld && bus.i_word_rdy) got.push_back(bus.o_word);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic b, input logic [7:0] llr,
                       input logic fl, output logic acc);
    bus.i_rd_vld   = vld;
    bus.i_hard_bit = b;
    bus.i_llr      = llr;
    bus.i_flush    = fl;
    acc = vld && bus.o_rd_rdy;
    @(posedge i_clk);
    #1;
    bus.i_rd_vld   = 1'b0;
    bus.i_hard_bit = 1'b0;
    bus.i_llr      = 8'h00;
    bus.i_flush    = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  function automatic logic fbit(input int k);
    return (((k * 13 + k / 7) % 5) < 2);
  endfunction

  function automatic logic [31:0] model_word(input int base);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = fbit(base + i);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       acc;
    logic [7:0] llr;
    logic       fl;
    int         k, cyc;

    vecs[0] = '{"alt55", 32'h5555_5555, 32, 8'hEC, 8'h14, -1, 8'h00, -1, 8'h00, 0,
                1'b1, 32'h5555_5555, 7'd20, 6'd32, 1'b0, 16'd0};
    vecs[1] = '{"mixmin", 32'hA5C3_0F1E, 32, 8'hCE, 8'h32, 7, 8'h80, 20, 8'h03, 0,
                1'b1, 32'hA5C3_0F1E, 7'd3, 6'd32, 1'b0, 16'd0};
    vecs[2] = '{"neg128", 32'hFFFF_FFFF, 32, 8'h80, 8'h80, -1, 8'h00, -1, 8'h00, 0,
                1'b1, 32'hFFFF_FFFF, 7'd127, 6'd32, 1'b0, 16'd0};
    vecs[3] = '{"flush13", 32'h0000_1ABC, 13, 8'h1E, 8'hE2, 5, 8'h7F, 12, 8'hF9, 2,
                1'b1, 32'h0000_1ABC, 7'd7, 6'd13, 1'b1, 16'd1};
    vecs[4] = '{"flush32", 32'h1234_5678, 32, 8'h64, 8'h9C, 31, 8'h00, -1, 8'h00, 1,
                1'b1, 32'h1234_5678, 7'd0, 6'd32, 1'b1, 16'd2};
    vecs[5] = '{"pm127", 32'h0F0F_0F0F, 32, 8'h7F, 8'h81, -1, 8'h00, -1, 8'h00, 0,
                1'b1, 32'h0F0F_0F0F, 7'd127, 6'd32, 1'b0, 16'd2};
    vecs[6] = '{"flush_midframe", 32'h0, 0, 8'h00, 8'h00, -1, 8'h00, -1, 8'h00, 2,
                1'b0, 32'h0, 7'd0, 6'd0, 1'b0, 16'd3};
    vecs[7] = '{"flush_idle", 32'h0, 0, 8'h00, 8'h00, -1, 8'h00, -1, 8'h00, 2,
                1'b0, 32'h0, 7'd0, 6'd0, 1'b0, 16'd3};

    bus.i_rd_vld   = 1'b0;
    bus.i_hard_bit = 1'b0;
    bus.i_llr      = 8'h00;
    bus.i_flush    = 1'b0;
    bus.i_word_rdy = 1'b1;
    i_reset        = 1'b1;

    // Reset state
    #1;
    check("rst_rd_rdy", bus.o_rd_rdy, 1);
    check("rst_word_vld", bus.o_word_vld, 0);
    check("rst_word", bus.o_word, 0);
    check("rst_min_abs", bus.o_min_abs, 0);
    check("rst_last", bus.o_frame_last, 0);
    check("rst_nbits", bus.o_nbits, 0);
    check("rst_frame_cnt", bus.o_frame_cnt, 0);
    do_reset();
    check("post_rst_rd_rdy", bus.o_rd_rdy, 1);

    // Table-driven single words
    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].nsend; i++) begin
        llr = (i % 2 == 0) ? vecs[v].llr_a : vecs[v].llr_b;
        if (i == vecs[v].spc1_pos) llr = vecs[v].spc1_llr;
        if (i == vecs[v].spc2_pos) llr = vecs[v].spc2_llr;
        fl = (vecs[v].flush_mode == 1) && (i == vecs[v].nsend - 1);
        drive(1'b1, vecs[v].bits[i], llr, fl, acc);
        if (i == 0) check({vecs[v].name, "_acc"}, acc, 1);
        if (vecs[v].nsend >= 2 && i == vecs[v].nsend - 2)
          check({vecs[v].name, "_early_vld"}, bus.o_word_vld, 0);
      end
      if (vecs[v].flush_mode == 2) drive(1'b0, 1'b0, 8'h00, 1'b1, acc);
      check({vecs[v].name, "_vld"}, bus.o_word_vld, vecs[v].exp_push);
      if (vecs[v].exp_push) begin
        check({vecs[v].name, "_word"}, bus.o_word, vecs[v].exp_word);
        check({vecs[v].name, "_min"}, bus.o_min_abs, vecs[v].exp_min);
        check({vecs[v].name, "_nbits"}, bus.o_nbits, vecs[v].exp_nbits);
        check({vecs[v].name, "_last"}, bus.o_frame_last, vecs[v].exp_last);
      end
      check({vecs[v].name, "_fc"}, bus.o_frame_cnt, vecs[v].exp_fc);
      drive(1'b0, 1'b0, 8'h00, 1'b0, acc);
      check({vecs[v].name, "_popped"}, bus.o_word_vld, 0);
    end

    // Full frame of 8 words, continuous bits
    do_reset();
    for (int w = 0; w < 8; w++) begin
      for (int i = 0; i < 32; i++) begin
        k = w * 32 + i;
        drive(1'b1, fbit(k), 8'(40 + (k % 9)), 1'b0, acc);
        if (!acc) check("frame_acc", acc, 1);
        if (i == 31) begin
          check($sformatf("frame_w%0d_vld", w), bus.o_word_vld, 1);
          check($sformatf("frame_w%0d_word", w), bus.o_word, model_word(w * 32));
          check($sformatf("frame_w%0d_last", w), bus.o_frame_last, (w == 7));
          if (w == 0) check("frame_w0_min", bus.o_min_abs, 40);
        end
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, acc);
    check("frame_cnt", bus.o_frame_cnt, 1);

    // Backpressure: fill the FIFO, stall, then release
    do_reset();
    bus.i_word_rdy = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 128 && cyc < 300) begin
      drive(1'b1, fbit(k), 8'h20, 1'b0, acc);
      if (acc) k++;
      cyc++;
    end
    check("stall_fill_bits", k, 128);
    check("stall_full_rdy", bus.o_rd_rdy, 0);
    check("stall_head_vld", bus.o_word_vld, 1);
    check("stall_head_word", bus.o_word, model_word(0));
    for (int s = 0; s < 5; s++) begin
      drive(1'b1, fbit(k), 8'h20, 1'b0, acc);
      check("stall_no_accept", acc, 0);
      check("stall_hold_word", bus.o_word, model_word(0));
    end
    mon_en = 1'b1;
    bus.i_word_rdy = 1'b1;
    drive(1'b1, fbit(k), 8'h20, 1'b0, acc);
    check("release_no_accept", acc, 0);
    check("release_rdy_up", bus.o_rd_rdy, 1);
    cyc = 0;
    while (k < 160 && cyc < 300) begin
      drive(1'b1, fbit(k), 8'h20, 1'b0, acc);
      if (acc) k++;
      cyc++;
    end
    check("release_bits", k, 160);
    repeat (6) drive(1'b0, 1'b0, 8'h00, 1'b0, acc);
    mon_en = 1'b0;
    check("release_word_count", got.size(), 5);
    for (int j = 0; j < 5; j++)
      if (j < got.size()) check($sformatf("release_word%0d", j), got[j], model_word(j * 32));
    // Five words into the frame, empty flush ends it
    drive(1'b0, 1'b0, 8'h00, 1'b1, acc);
    check("midframe_flush_fc", bus.o_frame_cnt, 1);

    // Reset with words queued and a partial word held
    bus.i_word_rdy = 1'b0;
    for (int i = 0; i < 81; i++) drive(1'b1, 1'b1, 8'h10, 1'b0, acc);
    check("prereset_vld", bus.o_word_vld, 1);
    check("prereset_fc", bus.o_frame_cnt, 1);
    #2;
    i_reset = 1'b1;
    #1;
    check("reset_vld_now", bus.o_word_vld, 0);
    check("reset_rdy_now", bus.o_rd_rdy, 1);
    check("reset_fc_now", bus.o_frame_cnt, 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    bus.i_word_rdy = 1'b1;
    begin
      logic [31:0] pat;
      pat = 32'hDEAD_BEEF;
      for (int i = 0; i < 32; i++) drive(1'b1, pat[i], 8'h11, 1'b0, acc);
    end
    check("postreset_vld", bus.o_word_vld, 1);
    check("postreset_word", bus.o_word, 32'hDEAD_BEEF);
    check("postreset_nbits", bus.o_nbits, 32);
    check("postreset_last", bus.o_frame_last, 0);
    check("postreset_fc", bus.o_frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
